aer_rx_ctrl: RTL and testbench



---
 rtl/aer_rx_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_aer_rx_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aer_rx_ctrl.sv
// Receive-side AER handshake controller: REQ sync, settle wait, address capture, 4-phase ACK, FWFT event FIFO.
// Optional `AER_TIMESTAMP_EN adds a free-running 32-bit timestamp stored with each event (port ev_ts).
module aer_rx_ctrl #(
  parameter int unsigned AER_W          = 10,
  parameter int unsigned SETTLE_CYC     = 3,
  parameter int unsigned TIMEOUT_CYC    = 1024,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter bit          REQ_ACTIVE_LOW = 1'b1,
  parameter bit          ACK_ACTIVE_LOW = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              aer_req,
  input  logic [AER_W-1:0]                  aer_data,
  output logic                              aer_ack,
  output logic                              ev_valid,
  input  logic                              ev_ready,
  output logic [AER_W-1:0]                  ev_data,
`ifdef AER_TIMESTAMP_EN
  output logic [31:0]                       ev_ts,
`endif
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              timeout_err,
  input  logic                              clr_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC);
  localparam int unsigned ST_W  = 4;
`ifdef AER_TIMESTAMP_EN
  localparam int unsigned ENT_W = AER_W + 32;
`else
  localparam int unsigned ENT_W = AER_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACK    = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_req_meta, r_req_sync;
  logic               w_req_s;
  logic [ST_W-1:0]    r_settle_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_aer_ack;
  logic               r_timeout_err;
  logic               w_capture, w_to_fire;

  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
  logic [LVL_W-1:0]   r_level, w_level_nxt;
  logic               r_ev_valid;
  logic [ENT_W-1:0]   r_head, w_head_nxt, w_din;
  logic               w_push, w_pop, w_full;

  // Two-flop synchroniser; idles at the deasserted REQ level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_meta <= REQ_ACTIVE_LOW;
      r_req_sync <= REQ_ACTIVE_LOW;
    end else begin
      r_req_meta <= aer_req;
      r_req_sync <= r_req_meta;
    end
  end

  assign w_req_s = r_req_sync ^ REQ_ACTIVE_LOW;
  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_to_fire   = 1'b0;
    case (r_state)
      S_IDLE:   if (w_req_s && !w_full) w_state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (r_settle_cnt == '0) begin
          w_state_nxt = S_ACK;
          w_capture   = 1'b1;
        end
      end
      S_ACK: begin
        if (!w_req_s) begin
          w_state_nxt = S_IDLE;
        end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt = S_ERR;
          w_to_fire   = 1'b1;
        end
      end
      S_ERR:    if (!w_req_s) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Settle / timeout counters, ACK output and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt  <= '0;
      r_to_cnt      <= '0;
      r_aer_ack     <= ACK_ACTIVE_LOW;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_state_nxt == S_SETTLE)
        r_settle_cnt <= ST_W'(SETTLE_CYC - 1);
      else if (r_state == S_SETTLE && r_settle_cnt != '0)
        r_settle_cnt <= r_settle_cnt - ST_W'(1);

      if (w_capture)
        r_to_cnt <= '0;
      else if (r_state == S_ACK && w_state_nxt == S_ACK)
        r_to_cnt <= r_to_cnt + TO_W'(1);

      r_aer_ack <= (w_state_nxt == S_ACK) ^ ACK_ACTIVE_LOW;

      if (w_to_fire)    r_timeout_err <= 1'b1;
      else if (clr_err) r_timeout_err <= 1'b0;
    end
  end

`ifdef AER_TIMESTAMP_EN
  logic [31:0] r_ts_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts_cnt <= '0;
    else        r_ts_cnt <= r_ts_cnt + 32'd1;
  end

  assign w_din = {r_ts_cnt, aer_data};
  assign ev_ts = r_head[ENT_W-1 -: 32];
`else
  assign w_din = aer_data;
`endif

  assign w_push   = w_capture;
  assign w_pop    = r_ev_valid & ev_ready;
  assign w_wr_nxt = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
  assign w_rd_nxt = w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LVL_W'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LVL_W'(1);
  end

  // Next head bypasses the array when the new entry lands at the next read slot
  assign w_head_nxt = (w_push && r_wr_ptr == w_rd_nxt) ? w_din : r_mem[w_rd_nxt];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_ev_valid <= 1'b0;
      r_head     <= '0;
    end else begin
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_level    <= w_level_nxt;
      r_ev_valid <= (w_level_nxt != '0);
      if (w_level_nxt != '0) r_head <= w_head_nxt;
    end
  end

  assign aer_ack     = r_aer_ack;
  assign ev_valid    = r_ev_valid;
  assign ev_data     = r_head[AER_W-1:0];
  assign fifo_level  = r_level;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_aer_rx_ctrl.sv
// Directed self-checking bench for aer_rx_ctrl (REQ active-low, ACK active-high, SETTLE 3, TIMEOUT 16, depth 4).
module tb_aer_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aer_req;
  logic [9:0]  aer_data;
  logic        aer_ack;
  logic        ev_valid;
  logic        ev_ready;
  logic [9:0]  ev_data;
  logic [2:0]  fifo_level;
  logic        timeout_err;
  logic        clr_err;
`ifdef AER_TIMESTAMP_EN
  logic [31:0] ev_ts;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  aer_rx_ctrl #(
    .AER_W(10), .SETTLE_CYC(3), .TIMEOUT_CYC(16), .FIFO_DEPTH(4),
    .REQ_ACTIVE_LOW(1'b1), .ACK_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .aer_req(aer_req), .aer_data(aer_data),
    .aer_ack(aer_ack), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
`ifdef AER_TIMESTAMP_EN
    .ev_ts(ev_ts),
`endif
    .fifo_level(fifo_level), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic exp, input int budget, input string tag);
    int n = 0;
    while (aer_ack !== exp && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(aer_ack), 32'(exp));
  endtask

  task automatic send_event(input logic [9:0] d, input string tag);
    aer_data = d;
    aer_req  = 1'b0;
    wait_ack(1'b1, 20, {tag, "_ack_on"});
    aer_req  = 1'b1;
    wait_ack(1'b0, 20, {tag, "_ack_off"});
  endtask

  initial begin
    logic [9:0] exp_q [4];
    int hi;
    int seen;
    int n;

    rst_n = 1'b0; aer_req = 1'b1; aer_data = '0; ev_ready = 1'b1; clr_err = 1'b0;
    #23;
    chk("rst_ack",   32'(aer_ack),     32'd0);
    chk("rst_valid", 32'(ev_valid),    32'd0);
    chk("rst_data",  32'(ev_data),     32'd0);
    chk("rst_level", 32'(fifo_level),  32'd0);
    chk("rst_terr",  32'(timeout_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // Single event latency and release
    aer_data = 10'h2A5;
    aer_req  = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    chk("t1_ack_e5", 32'(aer_ack), 32'd0);
    tick();
    chk("t1_ack_e6",   32'(aer_ack),    32'd1);
    chk("t1_valid_e6", 32'(ev_valid),   32'd1);
    chk("t1_data_e6",  32'(ev_data),    32'h2A5);
    chk("t1_level_e6", 32'(fifo_level), 32'd1);
    aer_req = 1'b1;
    tick();
    chk("t1_ack_r1",   32'(aer_ack),  32'd1);
    chk("t1_valid_r1", 32'(ev_valid), 32'd0);
    tick();
    chk("t1_ack_r2", 32'(aer_ack), 32'd1);
    tick();
    chk("t1_ack_r3", 32'(aer_ack), 32'd0);
    tick(); tick();

    // Backpressure with a full FIFO
    ev_ready = 1'b0;
    send_event(10'h101, "t2_e1");
    send_event(10'h102, "t2_e2");
    send_event(10'h103, "t2_e3");
    send_event(10'h104, "t2_e4");
    chk("t2_level_full", 32'(fifo_level), 32'd4);
    chk("t2_head",       32'(ev_data),    32'h101);
    aer_data = 10'h105;
    aer_req  = 1'b0;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (aer_ack) hi++;
    end
    chk("t2_bp_ack",   32'(hi),         32'd0);
    chk("t2_bp_level", 32'(fifo_level), 32'd4);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    chk("t2_pop_level", 32'(fifo_level), 32'd3);
    chk("t2_pop_head",  32'(ev_data),    32'h102);
    wait_ack(1'b1, 20, "t2_e5_ack_on");
    chk("t2_refill_level", 32'(fifo_level), 32'd4);
    aer_req = 1'b1;
    wait_ack(1'b0, 20, "t2_e5_ack_off");
    exp_q[0] = 10'h102; exp_q[1] = 10'h103; exp_q[2] = 10'h104; exp_q[3] = 10'h105;
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_valid", 32'(ev_valid), 32'd1);
      chk("t2_drain_data",  32'(ev_data),  32'(exp_q[i]));
      tick();
    end
    chk("t2_empty_level", 32'(fifo_level), 32'd0);
    chk("t2_empty_valid", 32'(ev_valid),   32'd0);

    // Handshake timeout, recovery and error clear
    aer_data = 10'h155;
    aer_req  = 1'b0;
    wait_ack(1'b1, 20, "t3_ack_on");
    n = 0;
    while (aer_ack && n < 40) begin
      tick();
      n++;
    end
    chk("t3_ack_cycles", 32'(n), 32'd16);
    chk("t3_terr",       32'(timeout_err), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ev_valid || aer_ack) seen++;
    end
    chk("t3_no_recapture", 32'(seen), 32'd0);
    aer_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    aer_data = 10'h0AA;
    aer_req  = 1'b0;
    wait_ack(1'b1, 20, "t3_re_ack_on");
    chk("t3_re_valid", 32'(ev_valid), 32'd1);
    chk("t3_re_data",  32'(ev_data),  32'h0AA);
    chk("t3_terr_hold", 32'(timeout_err), 32'd1);
    aer_req = 1'b1;
    wait_ack(1'b0, 20, "t3_re_ack_off");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_terr_clr", 32'(timeout_err), 32'd0);

    // Asynchronous reset while in ACK
    ev_ready = 1'b0;
    aer_data = 10'h3C3;
    aer_req  = 1'b0;
    wait_ack(1'b1, 20, "t4_ack_on");
    chk("t4_level_pre", 32'(fifo_level), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_ack_rst",   32'(aer_ack),    32'd0);
    chk("t4_level_rst", 32'(fifo_level), 32'd0);
    chk("t4_valid_rst", 32'(ev_valid),   32'd0);
    aer_req = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    ev_ready = 1'b1;
    tick(); tick();

    // Address bus settles late inside the settle window
    aer_data = 10'h000;
    aer_req  = 1'b0;
    tick(); tick();
    aer_data = 10'h3FF;
    wait_ack(1'b1, 20, "t5_ack_on");
    chk("t5_data", 32'(ev_data), 32'h3FF);
    aer_req = 1'b1;
    wait_ack(1'b0, 20, "t5_ack_off");

`ifdef AER_TIMESTAMP_EN
    begin
      logic [31:0] ts1;
      int a1;
      a1 = cyc;
      aer_data = 10'h011;
      aer_req  = 1'b0;
      wait_ack(1'b1, 20, "t6_e1_ack_on");
      ts1 = ev_ts;
      aer_req = 1'b1;
      wait_ack(1'b0, 20, "t6_e1_ack_off");
      while (cyc < a1 + 100) #1;
      #1;
      aer_data = 10'h022;
      aer_req  = 1'b0;
      wait_ack(1'b1, 20, "t6_e2_ack_on");
      chk("t6_ts_delta", ev_ts - ts1, 32'd100);
      aer_req = 1'b1;
      wait_ack(1'b0, 20, "t6_e2_ack_off");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
